mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the main ALU in the execute stage and holds operands.
- Runs a one-bit-per-cycle shift-add multiply or shift-subtract divide, then presents the result with a one-cycle done pulse.
- Control logic stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_WIDTH, 6, iteration counter width; must hold the value WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin operation with current op/SrcA/SrcB; sampled only in IDLE or DONE
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  WIDTH  rs1 operand (multiplicand / dividend)
SrcB  input  WIDTH  rs2 operand (multiplier / divisor)
busy  output  1  high while an operation is in flight (state CALC or FIX)
done  output  1  one-cycle pulse: Result valid this cycle
Result  output  WIDTH  final result; held stable until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: IDLE, busy=0, done=0, Result=0, counter=0, internal accumulators=0.
- Reset asserted mid-operation aborts on the next edge; no done pulse is produced.

States:
- IDLE: wait for start.
- CALC: iterate.
- FIX: sign correction.
- DONE: done=1 for exactly one cycle, then go to IDLE.

Transitions:
- IDLE/DONE + start: latch op and operand magnitudes (abs value for signed operands), record result sign, set counter=WIDTH, go to CALC.
- Exception: special-case divides go straight to DONE (see Special cases).
- CALC: one iteration per cycle, counter decrements; when counter reaches 1 the next state is FIX.
- FIX: negate the selected result if the sign flag is set, load Result, go to DONE.
- start outside IDLE/DONE is ignored; operands are not re-sampled.

Latency:
- Start sampled at edge 0; done is high in cycle WIDTH+2 (34 cycles for WIDTH=32).
- Special-case divides: done is high in the cycle after the start edge (cycle 1).

Multiply:
- Unsigned 2*WIDTH product built from operand magnitudes.
- MUL returns the low half. MULH, MULHSU and MULHU return the high half.
- Sign handling: MULH treats both operands as signed; MULHSU treats A as signed, B as unsigned; MULHU treats both as unsigned.
- Negation for a negative result is applied to the full 2*WIDTH product before selecting the half.

Divide:
- Restoring algorithm on magnitudes.
- Quotient sign = signA XOR signB for DIV.
- Remainder sign = signA for REM.
- DIVU and REMU are unsigned.

Special cases (no iteration):
- Divisor 0: DIV/DIVU return all ones; REM/REMU return SrcA.
- Signed overflow (SrcA = 0x80000000, SrcB = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.

Ordering and timing rules:
- Result updates only on entry to DONE; it is unchanged during CALC/FIX.
- busy=1 in CALC and FIX, 0 otherwise.
- done and busy are never both high.
- start in the DONE cycle is accepted: done still pulses that cycle and the next state is CALC (or DONE for a special case). Back-to-back throughput is one operation per WIDTH+2 cycles.
- No combinational path from start/SrcA/SrcB to any output; all outputs are registered.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at cycle 34, Result=0xFFFFFFEB; busy high cycles 1-33.
- MULH 0x80000000 x 0x80000000 -> Result=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done at cycle 34.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done in cycle 1.
- start pulsed again at cycles 5 and 20 during a MUL -> ignored, original result returned. start in the done cycle with DIVU 9/3 -> second done 34 cycles later, Result=3.
- rst asserted at cycle 10 of a DIV -> next cycle busy=0, done=0, Result=0. No done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer.
// Computes one bit per cycle on operand magnitudes, then applies a sign fix.
// Divide-by-zero and signed-overflow divides skip the iteration entirely.
module mdu_seq #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_next;
  logic [2:0]           op_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     opnd_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     hi_q;     // product high half / partial remainder
  logic [WIDTH-1:0]     lo_q;     // multiplier bits / dividend-then-quotient
  logic [CNT_WIDTH-1:0] cnt_q;

  // Operand decode at start time
  logic             accept, a_signed, b_signed, sign_a, sign_b;
  logic             div_zero, div_ovf, special, neg_d;
  logic [WIDTH-1:0] mag_a, mag_b, special_res;

  // Iteration and sign-fix datapath
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   div_sel, fix_res;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // Decode operands, signs and special cases presented with start
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    special_res = '1;
    accept   = start && ((state == IDLE) || (state == DONE));
    a_signed = op[2] ? !op[0] : (op[1:0] != 2'b11);
    b_signed = op[2] ? !op[0] : !op[1];
    sign_a   = a_signed && SrcA[WIDTH-1];
    sign_b   = b_signed && SrcB[WIDTH-1];
    mag_a    = sign_a ? -SrcA : SrcA;
    mag_b    = sign_b ? -SrcB : SrcB;
    div_zero = (SrcB == '0);
    div_ovf  = op[2] && !op[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    special  = op[2] && (div_zero || div_ovf);
    neg_d    = (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
    if (div_zero)
      special_res = op[1] ? SrcA : '1;
    else if (div_ovf)
      special_res = op[1] ? '0 : SrcA;
  end

  // One shift-add / shift-subtract step and the final sign correction
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod      = {hi_q, lo_q};
    prod_fix  = neg_q ? -prod : prod;
    div_sel   = op_q[1] ? hi_q : lo_q;
    if (op_q[2])
      fix_res = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 2'b00)
      fix_res = prod_fix[WIDTH-1:0];
    else
      fix_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = special ? DONE : CALC;
      CALC: if (cnt_q == CNT_WIDTH'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = start ? (special ? DONE : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration, result load
  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset too, so Result and accumulators read as zero after reset.
    if (rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      Result <= '0;
    end else if (accept) begin
      op_q   <= op;
      neg_q  <= neg_d;
      opnd_q <= op[2] ? mag_b : mag_a;
      hi_q   <= '0;
      lo_q   <= op[2] ? mag_a : mag_b;
      cnt_q  <= CNT_WIDTH'(WIDTH);
      if (special) Result <= special_res;
    end else if (state == CALC) begin
      cnt_q <= cnt_q - 1'b1;
      if (op_q[2]) begin
        hi_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
      end
    end else if (state == FIX) begin
      Result <= fix_res;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq with a cycle-level behavioural model.
module tb_mdu_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  SrcA = '0;
  logic [W-1:0]  SrcB = '0;
  logic          busy, done;
  logic [W-1:0]  Result;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  mdu_seq #(.WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M result from plain 64-bit arithmetic
  function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] up;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    up  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Behavioural timeline: togo counts cycles left until the done cycle
  int          togo = 0;
  logic        exp_busy = 1'b0, exp_done = 1'b0;
  logic [31:0] exp_res = '0, pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      togo <= 0; exp_busy <= 1'b0; exp_done <= 1'b0; exp_res <= '0;
    end else if (togo == 0 && start) begin
      if (is_special(op, SrcA, SrcB)) begin
        exp_done <= 1'b1; exp_busy <= 1'b0; exp_res <= model_result(op, SrcA, SrcB);
      end else begin
        togo <= LAT - 1; exp_busy <= 1'b1; exp_done <= 1'b0; pend <= model_result(op, SrcA, SrcB);
      end
    end else if (togo == 1) begin
      togo <= 0; exp_busy <= 1'b0; exp_done <= 1'b1; exp_res <= pend;
    end else if (togo > 1) begin
      togo <= togo - 1; exp_busy <= 1'b1; exp_done <= 1'b0;
    end else begin
      exp_busy <= 1'b0; exp_done <= 1'b0;
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   32'(busy), 32'(exp_busy));
      check("done",   32'(done), 32'(exp_done));
      check("result", Result, exp_res);
      check("busy_and_done", 32'(busy & done), 32'd0);
    end
  end

  // Launch one operation from the current negedge and wait for done
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int n;
    start = 1'b1; op = f; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_value"}, Result, exp);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    int seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", Result, 32'd0);
    idle(2);

    run_op(3'b000, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");      idle(1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh"); idle(1);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu"); idle(1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu"); idle(1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34, "div_m7_2");     idle(1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 34, "rem_m7_2");     idle(1);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");                idle(1);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");                 idle(1);
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");              idle(1);
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_by0");                       idle(1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"); idle(1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");       idle(1);

    // Extra start pulses mid-operation must be ignored
    start = 1'b1; op = 3'b000; SrcA = 32'h7; SrcB = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      if (n == 5 || n == 20) begin
        start = 1'b1; op = 3'b101; SrcA = $urandom; SrcB = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("ignored_start_latency", 32'(n), 32'd34);
    check("ignored_start_value", Result, 32'hFFFF_FFEB);

    // Start in the done cycle is accepted
    run_op(3'b101, 32'd9, 32'd3, 32'd3, 34, "b2b_divu_9_3");
    idle(2);

    // Reset mid-divide aborts with no done pulse
    start = 1'b1; op = 3'b100; SrcA = 32'hFFFF_FF9C; SrcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", Result, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, "fresh_div");

    // Randomised operations, including special divides and back-to-back starts
    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(rf, ra, rb, model_result(rf, ra, rb), is_special(rf, ra, rb) ? 1 : 34, "random");
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
